mw_writeback: RTL and testbench



---
 rtl/rv_pkg.sv | 20 ++
 rtl/mw_writeback_if.sv | 24 ++
 rtl/mw_writeback_load_align.sv | 38 +++
 rtl/mw_writeback.sv | 86 ++++++++
 tb/tb_mw_writeback.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 core definitions: datapath width, writeback source
// encodings and load funct3 codes.
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_LOAD = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_RSVD = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mw_writeback_if.sv
// Memory-stage to writeback bundle: the instruction leaving MEM plus the
// raw data-memory word that arrives during the WB cycle.
interface mw_writeback_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_valid;
  logic                  m_reg_write;
  logic [4:0]            m_rd;
  logic [1:0]            m_result_src;
  logic [2:0]            m_funct3;
  logic [DATA_WIDTH-1:0] m_alu_result;
  logic [DATA_WIDTH-1:0] m_pc_plus4;
  logic [31:0]           dmem_rdata;

  modport master (
    output m_valid, m_reg_write, m_rd, m_result_src, m_funct3,
           m_alu_result, m_pc_plus4, dmem_rdata
  );

  modport slave (
    input m_valid, m_reg_write, m_rd, m_result_src, m_funct3,
          m_alu_result, m_pc_plus4, dmem_rdata
  );
endinterface

// File: rtl/mw_writeback_load_align.sv
// Combinational load aligner: picks the byte/half/word addressed by the low
// address bits and sign- or zero-extends it according to funct3.
module load_align
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  // Halves ignore off[0]; there is no misalignment trap.
  assign byte_sel = lanes[off];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mw_writeback.sv
// MEM/WB pipeline register and writeback stage: drives the register-file
// write port, the forwarding tap and the retired-instruction counter.
module mw_writeback
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  mw_writeback_if.slave         m,
  output logic                  rf_we,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wd,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [CNT_WIDTH-1:0]  instret
);

  logic                  w_valid;
  logic                  w_reg_write;
  logic [4:0]            w_rd;
  result_src_e           w_src;
  logic [2:0]            w_funct3;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_pc4;
  logic [31:0]           load_data;
  logic [DATA_WIDTH-1:0] wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid     <= 1'b0;
      w_reg_write <= 1'b0;
      w_rd        <= '0;
      w_src       <= RESULT_ALU;
      w_funct3    <= '0;
      w_alu       <= '0;
      w_pc4       <= '0;
      instret     <= '0;
    end else begin
      // The instruction leaving W retires even if a flush lands on the same edge.
      if (w_valid && !stall)
        instret <= instret + CNT_WIDTH'(1);
      if (flush) begin
        w_valid     <= 1'b0;
        w_reg_write <= 1'b0;
      end else if (!stall) begin
        w_valid     <= m.m_valid;
        w_reg_write <= m.m_reg_write;
        w_rd        <= m.m_rd;
        w_src       <= result_src_e'(m.m_result_src);
        w_funct3    <= m.m_funct3;
        w_alu       <= m.m_alu_result;
        w_pc4       <= m.m_pc_plus4;
      end
    end
  end

  load_align u_load_align (
    .rdata  (m.dmem_rdata),
    .off    (w_alu[1:0]),
    .funct3 (w_funct3),
    .data   (load_data)
  );

  always_comb begin
    wd = w_alu;
    case (w_src)
      RESULT_LOAD: wd = DATA_WIDTH'(load_data);
      RESULT_PC4:  wd = w_pc4;
      default:     wd = w_alu;
    endcase
  end

  // Forwarding stays live through a stall; only the actual write is held off.
  assign fwd_valid = w_valid && w_reg_write && (w_rd != 5'd0);
  assign rf_we     = fwd_valid && !stall;
  assign rf_rd     = w_rd;
  assign rf_wd     = wd;
  assign fwd_rd    = w_rd;
  assign fwd_data  = wd;

endmodule

// File: tb/tb_mw_writeback.sv
// Bench for mw_writeback: directed load/stall/flush/reset vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_mw_writeback;
  import rv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush;
  mw_writeback_if #(.DATA_WIDTH(32)) mif ();

  logic        rf_we, fwd_valid;
  logic [4:0]  rf_rd, fwd_rd;
  logic [31:0] rf_wd, fwd_data;
  logic [63:0] instret;

  logic        rf_we_s, fwd_valid_s;
  logic [4:0]  rf_rd_s, fwd_rd_s;
  logic [31:0] rf_wd_s, fwd_data_s;
  logic [3:0]  instret_s;

  mw_writeback #(.DATA_WIDTH(32), .CNT_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .m(mif),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret)
  );

  // Narrow-counter copy so wraparound is reachable in a short run.
  mw_writeback #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .m(mif),
    .rf_we(rf_we_s), .rf_rd(rf_rd_s), .rf_wd(rf_wd_s),
    .fwd_valid(fwd_valid_s), .fwd_rd(fwd_rd_s), .fwd_data(fwd_data_s),
    .instret(instret_s)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: the instruction currently in writeback and the retirement count.
  bit          started = 0;
  bit          mvalid, mrw, mknown;
  logic [4:0]  mrd;
  logic [1:0]  msrc;
  logic [2:0]  mf3;
  logic [31:0] malu, mpc4;
  longint unsigned mcnt;

  function automatic logic [31:0] expect_wd(input logic [1:0] src, input logic [2:0] f3,
                                            input logic [31:0] alu, input logic [31:0] pc4,
                                            input logic [31:0] rdata);
    int unsigned off, b, h;
    if (src == 2'b10) return pc4;
    if (src != 2'b01) return alu;
    off = int'(alu[1:0]);
    b = (rdata >> (8 * off)) & 32'hFF;
    h = (off >= 2) ? (rdata >> 16) : (rdata & 32'hFFFF);
    case (f3)
      3'b000:  return (b >= 128) ? (32'hFFFFFF00 | b) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? (32'hFFFF0000 | h) : h;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      mvalid = 0; mrw = 0; mrd = 0; msrc = 0; mf3 = 0; malu = 0; mpc4 = 0;
      mknown = 1; mcnt = 0;
    end else if (started) begin
      if (mvalid && !stall) mcnt = mcnt + 1;
      if (flush) begin
        mvalid = 0; mrw = 0; mknown = 0;
      end else if (!stall) begin
        mvalid = mif.m_valid;  mrw  = mif.m_reg_write; mrd = mif.m_rd;
        msrc   = mif.m_result_src; mf3 = mif.m_funct3;
        malu   = mif.m_alu_result; mpc4 = mif.m_pc_plus4; mknown = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic exp_fv;
      logic [31:0] ewd;
      exp_fv = mvalid && mrw && (mrd != 5'd0);
      chk("model_fwd_valid", 64'(fwd_valid), 64'(exp_fv));
      chk("model_rf_we", 64'(rf_we), 64'(exp_fv && !stall));
      chk("model_instret", instret, mcnt);
      chk("model_instret_narrow", 64'(instret_s), mcnt & 64'hF);
      if (mknown) begin
        ewd = expect_wd(msrc, mf3, malu, mpc4, mif.dmem_rdata);
        chk("model_rf_rd", 64'(rf_rd), 64'(mrd));
        chk("model_fwd_rd", 64'(fwd_rd), 64'(mrd));
        chk("model_rf_wd", 64'(rf_wd), 64'(ewd));
        chk("model_fwd_data", 64'(fwd_data), 64'(ewd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
    mif.m_valid = v; mif.m_reg_write = rw; mif.m_rd = rd; mif.m_result_src = src;
    mif.m_funct3 = f3; mif.m_alu_result = alu; mif.m_pc_plus4 = pc4;
    $display("[TB] issue v=%0d rw=%0d rd=%0d src=%0d f3=%0d alu=%h pc4=%h stall=%0d flush=%0d",
             v, rw, rd, src, f3, alu, pc4, stall, flush);
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; mif.dmem_rdata = 32'h0;
    bubble();
    tick(); tick();
    @(negedge clk);
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_rf_rd", 64'(rf_rd), 64'd0);
    chk("reset_rf_wd", 64'(rf_wd), 64'd0);
    chk("reset_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("reset_instret", instret, 64'd0);
    rst = 1'b0;

    drive(1, 1, 5'd5, 2'b00, 3'b010, 32'h0000_1234, 32'h0);
    tick();
    drive(1, 1, 5'd6, 2'b01, 3'b000, 32'h1000_0002, 32'h0);
    @(negedge clk);
    chk("alu_rf_we", 64'(rf_we), 64'd1);
    chk("alu_rf_rd", 64'(rf_rd), 64'd5);
    chk("alu_rf_wd", 64'(rf_wd), 64'h1234);
    tick();
    mif.dmem_rdata = 32'h12F4_5678;
    drive(1, 1, 5'd6, 2'b01, 3'b100, 32'h1000_0002, 32'h0);
    @(negedge clk);
    chk("alu_instret", instret, 64'd1);
    chk("lb_wd", 64'(rf_wd), 64'hFFFF_FFF4);
    tick();
    drive(1, 1, 5'd6, 2'b01, 3'b001, 32'h1000_0002, 32'h0);
    @(negedge clk);
    chk("lbu_wd", 64'(rf_wd), 64'h0000_00F4);
    tick();
    mif.dmem_rdata = 32'h8001_7FFF;
    drive(1, 1, 5'd6, 2'b01, 3'b101, 32'h1000_0000, 32'h0);
    @(negedge clk);
    chk("lh_wd", 64'(rf_wd), 64'hFFFF_8001);
    tick();
    drive(1, 1, 5'd6, 2'b01, 3'b010, 32'h1000_0003, 32'h0);
    @(negedge clk);
    chk("lhu_wd", 64'(rf_wd), 64'h0000_7FFF);
    tick();
    drive(1, 1, 5'd7, 2'b01, 3'b010, 32'h0000_0020, 32'h0);
    @(negedge clk);
    chk("lw_wd", 64'(rf_wd), 64'h8001_7FFF);
    chk("lw_instret", instret, 64'd5);

    // Load held in WB by a three-cycle stall.
    tick();
    mif.dmem_rdata = 32'hCAFE_BABE;
    stall = 1'b1;
    drive(1, 1, 5'd8, 2'b00, 3'b000, 32'h0000_0055, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rf_we", 64'(rf_we), 64'd0);
      chk("stall_fwd_valid", 64'(fwd_valid), 64'd1);
      chk("stall_instret", instret, 64'd6);
    end
    stall = 1'b0;
    #1;
    chk("release_rf_we", 64'(rf_we), 64'd1);
    chk("release_rf_rd", 64'(rf_rd), 64'd7);
    chk("release_rf_wd", 64'(rf_wd), 64'hCAFE_BABE);
    tick();
    drive(1, 1, 5'd0, 2'b00, 3'b000, 32'h0000_0099, 32'h0);
    @(negedge clk);
    chk("after_stall_rd", 64'(rf_rd), 64'd8);
    chk("after_stall_instret", instret, 64'd7);
    tick();
    drive(1, 1, 5'd1, 2'b10, 3'b000, 32'h0000_0040, 32'h0000_0104);
    @(negedge clk);
    chk("rd0_rf_we", 64'(rf_we), 64'd0);
    chk("rd0_fwd_valid", 64'(fwd_valid), 64'd0);
    tick();
    drive(1, 1, 5'd9, 2'b00, 3'b000, 32'h0000_0077, 32'h0);
    @(negedge clk);
    chk("jal_rf_wd", 64'(rf_wd), 64'h104);
    chk("jal_rf_rd", 64'(rf_rd), 64'd1);
    chk("rd0_counted_instret", instret, 64'd9);

    // Flush together with stall: bubble, nothing counted.
    tick();
    flush = 1'b1; stall = 1'b1;
    drive(1, 1, 5'd10, 2'b00, 3'b000, 32'h0000_00AA, 32'h0);
    tick();
    flush = 1'b0; stall = 1'b0;
    drive(1, 1, 5'd11, 2'b00, 3'b000, 32'h0000_00BB, 32'h0);
    @(negedge clk);
    chk("flush_stall_rf_we", 64'(rf_we), 64'd0);
    chk("flush_stall_fwd", 64'(fwd_valid), 64'd0);
    chk("flush_stall_instret", instret, 64'd10);

    // Flush alone still lets the W instruction retire.
    tick();
    flush = 1'b1;
    drive(1, 1, 5'd12, 2'b00, 3'b000, 32'h0000_00CC, 32'h0);
    tick();
    flush = 1'b0;
    drive(1, 1, 5'd13, 2'b00, 3'b000, 32'h0000_00DD, 32'h0);
    @(negedge clk);
    chk("flush_rf_we", 64'(rf_we), 64'd0);
    chk("flush_instret", instret, 64'd11);

    // Reset while a stalled instruction is held.
    tick();
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    bubble();
    @(negedge clk);
    chk("rst_stall_instret", instret, 64'd0);
    chk("rst_stall_fwd", 64'(fwd_valid), 64'd0);

    // 18 back-to-back retirements wrap the 4-bit counter to 2.
    for (int i = 0; i < 18; i++) begin
      drive(1, 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom);
      mif.dmem_rdata = $urandom;
      tick();
    end
    bubble();
    tick(); tick();
    @(negedge clk);
    chk("run_instret", instret, 64'd18);
    chk("wrap_instret_narrow", 64'(instret_s), 64'd2);

    // Mixed traffic with stalls and flushes, checked by the model.
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      drive(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom);
      mif.dmem_rdata = $urandom;
      tick();
    end
    stall = 1'b0; flush = 1'b0;
    bubble();
    tick(); tick();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
